// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, picks the next PC from the
// sequential / branch / jump / jump-register sources, validates every
// target against the instruction memory window and stops fetching on
// the first illegal target. Leaving HALT requires a reset.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_LAST  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic [31:0] im_instr,
  output logic [11:0] instr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        halted,
  output logic [31:0] exc_pc,
  output logic [15:0] fetch_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        halted_reg, halted_next;
  logic [31:0] exc_pc_reg, exc_pc_next;
  logic [15:0] fetch_cnt_reg, fetch_cnt_next;

  logic [31:0] pc_off;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        npc_legal;

  // Word offset into the window drives the memory; PC+4 is the link value.
  always_comb begin
    pc_off   = pc_reg - PC_RESET;
    pc_plus4 = pc_reg + 32'd4;
    br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  end

  // Next-PC candidate selection and window/alignment legality check.
  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      SEL_SEQ: npc = pc_plus4;
      SEL_BR:  npc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      SEL_J:   npc = {pc_reg[31:28], imm26, 2'b00};
      SEL_JR:  npc = rs_val;
      default: npc = pc_plus4;
    endcase
    npc_legal = (npc[1:0] == 2'b00) && (npc >= PC_RESET) && (npc <= PC_LAST);
  end

  // FSM next-state: advance on a legal target, trap on an illegal one.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    halted_next    = halted_reg;
    exc_pc_next    = exc_pc_reg;
    fetch_cnt_next = fetch_cnt_reg;
    case (state_reg)
      RUN: begin
        if (!stall) begin
          if (npc_legal) begin
            pc_next = npc;
            if (fetch_cnt_reg != 16'hFFFF) begin
              fetch_cnt_next = fetch_cnt_reg + 16'd1;
            end
          end else begin
            state_next  = HALT;
            halted_next = 1'b1;
            exc_pc_next = npc;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State registers; reset wins over stall and over HALT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= RUN;
      pc_reg        <= PC_RESET;
      halted_reg    <= 1'b0;
      exc_pc_reg    <= 32'h0000_0000;
      fetch_cnt_reg <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      halted_reg    <= halted_next;
      exc_pc_reg    <= exc_pc_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  // Output drive; decode sees a nop once fetch has stopped.
  always_comb begin
    instr_addr = pc_off[13:2];
    pc         = pc_reg;
    halted     = halted_reg;
    exc_pc     = exc_pc_reg;
    fetch_cnt  = fetch_cnt_reg;
    instr      = (state_reg == HALT) ? 32'h0000_0000 : im_instr;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed walk through the fetch scenarios, then
// randomized traffic. A behavioural model predicts each cycle's outputs
// into a queue; a negedge monitor pops and compares.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] im_instr;
  logic [11:0] instr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        halted;
  logic [31:0] exc_pc;
  logic [15:0] fetch_cnt;

  ifu_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .imm16      (imm16),
    .imm26      (imm26),
    .rs_val     (rs_val),
    .im_instr   (im_instr),
    .instr_addr (instr_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .halted     (halted),
    .exc_pc     (exc_pc),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable pattern per word address.
  function automatic logic [31:0] memw(input logic [11:0] a);
    return {a, ~a, 8'h5A};
  endfunction

  assign im_instr = memw(instr_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [11:0] addr;
    logic [31:0] instr;
    logic        halted;
    logic [31:0] exc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  // Reference model state.
  bit [31:0] m_pc   = 32'h3000;
  bit        m_halt = 1'b0;
  bit [31:0] m_exc  = 32'h0;
  bit [15:0] m_cnt  = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
  endtask

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic cyc(input logic rst, input logic st, input logic [1:0] sel,
                     input logic br, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [31:0] rs, input bit chk_en);
    exp_t e;
    bit [31:0] npc;
    bit [31:0] woff;
    reset_n  = rst;
    stall    = st;
    npc_sel  = sel;
    br_taken = br;
    imm16    = i16;
    imm26    = i26;
    rs_val   = rs;
    if (chk_en) begin
      woff     = (m_pc - 32'h3000) / 4;
      e.pc     = m_pc;
      e.pc4    = m_pc + 32'd4;
      e.addr   = woff[11:0];
      e.instr  = m_halt ? 32'h0 : memw(woff[11:0]);
      e.halted = m_halt;
      e.exc    = m_exc;
      e.cnt    = m_cnt;
      sb.push_back(e);
      $display("cyc rst=%0b stall=%0b sel=%0d pc=0x%08h halt=%0b cnt=%0d", rst, st, sel, m_pc, m_halt, m_cnt);
    end
    if (!rst) begin
      m_pc = 32'h3000; m_halt = 1'b0; m_exc = 32'h0; m_cnt = 16'h0;
    end else if (!m_halt && !st) begin
      case (sel)
        2'd0: npc = m_pc + 32'd4;
        2'd1: npc = br ? m_pc + 32'd4 + 32'(int'($signed(i16)) * 4) : m_pc + 32'd4;
        2'd2: npc = (m_pc & 32'hF000_0000) + 32'(i26) * 32'd4;
        default: npc = rs;
      endcase
      if ((npc % 4 == 0) && npc >= 32'h3000 && npc <= 32'h6FFC) begin
        m_pc = npc;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_halt = 1'b1;
        m_exc  = npc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents outputs every cycle; compare against the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc4);
      chk("instr_addr", {20'h0, instr_addr}, {20'h0, e.addr});
      chk("instr", instr, e.instr);
      chk("halted", {31'h0, halted}, {31'h0, e.halted});
      chk("exc_pc", exc_pc, e.exc);
      chk("fetch_cnt", {16'h0, fetch_cnt}, {16'h0, e.cnt});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r_sel;
    logic [15:0] r_i16;
    logic [25:0] r_i26;
    logic [31:0] r_rs;
    logic [31:0] tgt;

    // 1: reset then sequential fetch
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk("tp1_pc", pc, 32'h300C);
    chk("tp1_addr", {20'h0, instr_addr}, 32'h3);
    chk("tp1_cnt", {16'h0, fetch_cnt}, 32'd3);

    // 2: branch taken / not taken from 0x3010
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b1);
    cyc(1'b1, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b1);
    chk("tp2_taken", pc, 32'h3004);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b1);
    cyc(1'b1, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b1);
    chk("tp2_not_taken", pc, 32'h3014);

    // 3: jump and jump-register
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b1);
    chk("tp3_j_pc", pc, 32'h3100);
    chk("tp3_j_addr", {20'h0, instr_addr}, 32'h040);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3200, 1'b1);
    chk("tp3_jr_pc", pc, 32'h3200);

    // 4: stall holds, then jump taken when stall drops
    repeat (2) cyc(1'b1, 1'b1, 2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b1);
    chk("tp4_stall_pc", pc, 32'h3200);
    chk("tp4_stall_cnt", {16'h0, fetch_cnt}, 32'd9);
    cyc(1'b1, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b1);
    chk("tp4_jump_pc", pc, 32'h3100);
    chk("tp4_jump_cnt", {16'h0, fetch_cnt}, 32'd10);

    // 5: misaligned jr target halts; further inputs ignored
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3202, 1'b1);
    chk("tp5_halted", {31'h0, halted}, 32'h1);
    chk("tp5_exc", exc_pc, 32'h3202);
    chk("tp5_instr", instr, 32'h0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), $urandom, 1'b1);
    chk("tp5_frozen_pc", pc, 32'h3100);
    chk("tp5_frozen_exc", exc_pc, 32'h3202);
    chk("tp5_frozen_cnt", {16'h0, fetch_cnt}, 32'd10);

    // 6: reset out of HALT, end of window, branch below window
    cyc(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h1, 1'b1);
    chk("tp6_rst_pc", pc, 32'h3000);
    chk("tp6_rst_halted", {31'h0, halted}, 32'h0);
    chk("tp6_rst_exc", exc_pc, 32'h0);
    cyc(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h6FFC, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk("tp6_end_halted", {31'h0, halted}, 32'h1);
    chk("tp6_end_exc", exc_pc, 32'h7000);
    chk("tp6_end_pc", pc, 32'h6FFC);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b1);
    chk("tp6_br_low_exc", exc_pc, 32'h2FFC);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);

    // Randomized traffic, mostly legal targets, occasional resets
    for (int i = 0; i < 2000; i++) begin
      r_sel = 2'($urandom);
      tgt   = 32'h3000 + ($urandom_range(0, 4095) << 2);
      r_rs  = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
      r_i26 = ($urandom_range(0, 3) != 0) ? 26'(tgt >> 2) : 26'($urandom);
      r_i16 = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 63)) - 16'd32 : 16'($urandom);
      cyc(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0), r_sel,
          1'($urandom), r_i16, r_i26, r_rs, 1'b1);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
